// File: rtl/step_input_pkg.sv
// Shared constants for the step/KEY input conditioner: event field layout and
// default parameter values.
package step_input_pkg;

   localparam int unsigned NUM_KEYS  = 4;
   localparam int unsigned KEY_IDX_W = 2;
   localparam int unsigned DEB_CNT_W = 20;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
   localparam int unsigned DEF_FIFO_DEPTH      = 8;
   localparam int unsigned DEF_TS_WIDTH        = 24;

   // Event word: {key_idx, pressed, timestamp}, timestamp in the low bits.
   localparam int unsigned TS_LSB      = 0;
   localparam int unsigned PRESSED_BIT = TS_LSB + DEF_TS_WIDTH;
   localparam int unsigned KEY_IDX_LSB = PRESSED_BIT + 1;

   function automatic int unsigned evt_width(input int unsigned ts_w);
      return KEY_IDX_W + 1 + ts_w;
   endfunction

endpackage

// File: rtl/step_debounce.sv
// One key: 2-flop synchronizer followed by a stable-level debounce counter.
// update_c is high in the cycle before key_clean_n takes the new level.
module step_debounce
   import step_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n_raw,
   output logic key_clean_n,
   output logic update_c
);

   logic [1:0]           sync;
   logic [DEB_CNT_W-1:0] cnt;
   logic                 differ;

   assign differ   = sync[1] != key_clean_n;
   assign update_c = differ && (cnt == DEB_CNT_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync        <= 2'b11;
         cnt         <= '0;
         key_clean_n <= 1'b1;
      end else begin
         sync <= {sync[0], key_n_raw};
         if (update_c) begin
            key_clean_n <= sync[1];
            cnt         <= '0;
         end else if (differ) begin
            cnt <= cnt + DEB_CNT_W'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/step_input_conditioner.sv
// Debounced step/KEY inputs with timestamped press/release events queued in a
// first-word-fall-through FIFO and a sticky overflow flag.
module step_input_conditioner
   import step_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH,
   parameter int unsigned TS_WIDTH        = DEF_TS_WIDTH
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [NUM_KEYS-1:0] key_n_raw,
   output logic [NUM_KEYS-1:0] key_clean_n,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [TS_WIDTH+2:0] evt_data,
   output logic                evt_overflow,
   input  logic                overflow_clear,
   input  logic                ts_clear
);

   localparam int unsigned EVT_W = evt_width(TS_WIDTH);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [NUM_KEYS-1:0]  upd;
   logic [TS_WIDTH-1:0]  ts;
   logic [TS_WIDTH-1:0]  ts_next;
   logic [NUM_KEYS-1:0]  pending;
   logic [NUM_KEYS-1:0]  pend_pressed;
   logic [TS_WIDTH-1:0]  pend_ts [NUM_KEYS];
   logic [NUM_KEYS-1:0]  grant;
   logic                 wr_req;
   logic [KEY_IDX_W-1:0] wr_idx;
   logic [EVT_W-1:0]     wr_data;

   logic [EVT_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     rd_ptr_next;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     count_next;
   logic [EVT_W-1:0]     head_next;
   logic                 full;
   logic                 pop;
   logic                 push;
   logic                 drop;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      step_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk         (clk_clk),
         .rst         (reset_reset),
         .key_n_raw   (key_n_raw[k]),
         .key_clean_n (key_clean_n[k]),
         .update_c    (upd[k])
      );
   end

   // Free-running timestamp; events capture the value seen in the change cycle.
   assign ts_next = ts_clear ? '0 : ts + TS_WIDTH'(1);

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         ts <= '0;
      end else begin
         ts <= ts_next;
      end
   end

   // Pending flags: a new change wins over the grant clearing the same key.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         pending      <= '0;
         pend_pressed <= '0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            pend_ts[k] <= '0;
         end
      end else begin
         pending <= upd | (pending & ~grant);
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (upd[k]) begin
               pend_ts[k]      <= ts_next;
               pend_pressed[k] <= key_clean_n[k];
            end
         end
      end
   end

   // Lowest-index pending key gets the single FIFO write slot.
   always_comb begin
      grant  = '0;
      wr_req = 1'b0;
      wr_idx = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (pending[k] && !wr_req) begin
            grant[k] = 1'b1;
            wr_req   = 1'b1;
            wr_idx   = KEY_IDX_W'(k);
         end
      end
   end

   always_comb begin
      wr_data = '0;
      wr_data[TS_LSB +: TS_WIDTH]              = pend_ts[wr_idx];
      wr_data[TS_LSB + TS_WIDTH]               = pend_pressed[wr_idx];
      wr_data[TS_LSB + TS_WIDTH + 1 +: KEY_IDX_W] = wr_idx;
   end

   assign full        = count == CNT_W'(FIFO_DEPTH);
   assign pop         = evt_valid && evt_ready;
   assign push        = wr_req && (!full || pop);
   assign drop        = wr_req && full && !pop;
   assign count_next  = count + CNT_W'(push) - CNT_W'(pop);
   assign rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

   // The head register is loaded with whatever will sit at the read pointer,
   // bypassing the array when the write lands in the head slot.
   assign head_next = (push && (wr_ptr == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         evt_valid    <= 1'b0;
         evt_data     <= '0;
         evt_overflow <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         rd_ptr    <= rd_ptr_next;
         count     <= count_next;
         evt_valid <= count_next != '0;
         evt_data  <= head_next;
         if (drop) begin
            evt_overflow <= 1'b1;
         end else if (overflow_clear) begin
            evt_overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_step_input_conditioner.sv
// Bench for step_input_conditioner: directed scenarios plus randomized key
// activity, all outputs compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_step_input_conditioner;
   import step_input_pkg::*;

   localparam int unsigned DEB   = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned TSW   = 24;
   localparam int unsigned EW    = TSW + 3;
   localparam int unsigned HIST  = DEB + 2;

   logic          clk_clk = 1'b0;
   logic          reset_reset;
   logic [3:0]    key_n_raw;
   logic [3:0]    key_clean_n;
   logic          evt_valid;
   logic          evt_ready;
   logic [EW-1:0] evt_data;
   logic          evt_overflow;
   logic          overflow_clear;
   logic          ts_clear;

   always #5 clk_clk = ~clk_clk;

   step_input_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .FIFO_DEPTH     (DEPTH),
      .TS_WIDTH       (TSW)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset   (reset_reset),
      .key_n_raw     (key_n_raw),
      .key_clean_n   (key_clean_n),
      .evt_valid     (evt_valid),
      .evt_ready     (evt_ready),
      .evt_data      (evt_data),
      .evt_overflow  (evt_overflow),
      .overflow_clear(overflow_clear),
      .ts_clear      (ts_clear)
   );

   // Model: raw sample history, pending events per key, event queue.
   logic [3:0]     hist [$];
   logic [3:0]     m_clean;
   logic [3:0]     m_pend;
   logic [EW-1:0]  m_pev [4];
   logic [EW-1:0]  m_q [$];
   logic           m_ovf;
   logic [TSW-1:0] m_ts;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      hist.delete();
      for (int j = 0; j < HIST; j++) hist.push_back(4'hF);
      m_clean = 4'hF;
      m_pend  = '0;
      for (int k = 0; k < 4; k++) m_pev[k] = '0;
      m_q.delete();
      m_ovf = 1'b0;
      m_ts  = '0;
   endfunction

   // A key's clean level flips once the DEB raw samples taken before the two
   // newest ones all disagree with it; the change cycle's timestamp is recorded.
   function automatic void model_step();
      logic [TSW-1:0] ts_new;
      logic           wr;
      logic           drop;
      logic [EW-1:0]  wd;
      logic [3:0]     flip;
      ts_new = ts_clear ? '0 : m_ts + 1'b1;
      wr = 1'b0;
      wd = '0;
      for (int k = 0; k < 4; k++) begin
         if (m_pend[k] && !wr) begin
            wr = 1'b1;
            wd = m_pev[k];
            m_pend[k] = 1'b0;
         end
      end
      if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
      drop = 1'b0;
      if (wr) begin
         if (m_q.size() < DEPTH) m_q.push_back(wd);
         else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (overflow_clear) m_ovf = 1'b0;
      hist.push_back(key_n_raw);
      void'(hist.pop_front());
      flip = '0;
      for (int k = 0; k < 4; k++) begin
         flip[k] = 1'b1;
         for (int j = 0; j < DEB; j++) begin
            if (hist[j][k] == m_clean[k]) flip[k] = 1'b0;
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (flip[k]) begin
            m_clean[k] = ~m_clean[k];
            m_pend[k]  = 1'b1;
            m_pev[k]   = {2'(k), ~m_clean[k], ts_new};
         end
      end
      m_ts = ts_new;
   endfunction

   task automatic compare_all();
      check("key_clean_n", key_clean_n, m_clean);
      check("evt_valid", evt_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("evt_data", evt_data, m_q[0]);
      check("evt_overflow", evt_overflow, m_ovf);
   endtask

   task automatic tick();
      @(posedge clk_clk);
      if (reset_reset) model_reset();
      else model_step();
      #1;
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int hold;
      int rdy_pct;
      reset_reset    = 1'b0;
      key_n_raw      = 4'hF;
      evt_ready      = 1'b0;
      overflow_clear = 1'b0;
      ts_clear       = 1'b0;
      model_reset();
      #1 reset_reset = 1'b1;
      #1;
      check("rst_valid", evt_valid, 1'b0);
      check("rst_clean", key_clean_n, 4'hF);
      check("rst_data", evt_data, '0);
      check("rst_ovf", evt_overflow, 1'b0);
      ticks(2);
      reset_reset = 1'b0;

      // Single press on key0: latency and first event
      evt_ready = 1'b1;
      key_n_raw = 4'hE;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 17) check("lat_before", key_clean_n[0], 1'b1);
         if (i == 18) check("lat_at", key_clean_n[0], 1'b0);
         if (i == 19) begin
            check("k0_valid", evt_valid, 1'b1);
            check("k0_idx", evt_data[KEY_IDX_LSB +: KEY_IDX_W], 2'd0);
            check("k0_pressed", evt_data[PRESSED_BIT], 1'b1);
         end
      end
      key_n_raw = 4'hF;
      ticks(25);

      // Key2 glitches never pass
      key_n_raw = 4'hB;
      ticks(10);
      for (int b = 0; b < 5; b++) begin
         key_n_raw = 4'hF;
         ticks(2);
         key_n_raw = 4'hB;
         ticks(3);
      end
      key_n_raw = 4'hF;
      ticks(20);
      check("glitch_clean", key_clean_n, 4'hF);
      check("glitch_none", evt_valid, 1'b0);

      // Keys 1 and 3 released together
      key_n_raw = 4'b0101;
      ticks(25);
      evt_ready = 1'b0;
      key_n_raw = 4'hF;
      ticks(25);
      check("rel1_idx", evt_data[KEY_IDX_LSB +: KEY_IDX_W], 2'd1);
      check("rel1_pressed", evt_data[PRESSED_BIT], 1'b0);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check("rel3_idx", evt_data[KEY_IDX_LSB +: KEY_IDX_W], 2'd3);
      check("rel3_pressed", evt_data[PRESSED_BIT], 1'b0);
      evt_ready = 1'b1;
      ticks(5);

      // Overflow: 10 changes into an 8-deep FIFO with no consumer
      evt_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         key_n_raw = (c % 2 == 0) ? 4'hE : 4'hF;
         ticks(20);
      end
      check("ovf_set", evt_overflow, 1'b1);
      overflow_clear = 1'b1;
      tick();
      overflow_clear = 1'b0;
      check("ovf_clr", evt_overflow, 1'b0);
      evt_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check("drain_valid", evt_valid, 1'b1);
         check("drain_pressed", evt_data[PRESSED_BIT], (k % 2 == 0) ? 1'b1 : 1'b0);
         tick();
      end
      check("drain_empty", evt_valid, 1'b0);

      // Timestamp wrap between two events
      evt_ready = 1'b0;
      key_n_raw = 4'hE;
      tick();
      key_n_raw = 4'hC;
      ticks(4);
      force dut.ts = 24'hFFFFF2;
      #1 release dut.ts;
      m_ts = 24'hFFFFF2;
      ticks(16);
      check("wrap_first", evt_data, {2'd0, 1'b1, 24'hFFFFFF});
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check("wrap_second", evt_data, {2'd1, 1'b1, 24'h000000});
      evt_ready = 1'b1;
      key_n_raw = 4'hF;
      ticks(25);

      // Reset with queued events and key0 mid-debounce
      evt_ready = 1'b0;
      key_n_raw = 4'b0001;
      ticks(22);
      key_n_raw = 4'b0000;
      ticks(8);
      #2 reset_reset = 1'b1;
      #1;
      model_reset();
      check("rst2_valid", evt_valid, 1'b0);
      check("rst2_clean", key_clean_n, 4'hF);
      check("rst2_ovf", evt_overflow, 1'b0);
      ticks(2);
      reset_reset = 1'b0;
      evt_ready = 1'b1;
      tick();
      check("no_stale", evt_valid, 1'b0);
      ticks(30);
      key_n_raw = 4'hF;
      ticks(30);

      // Randomized key activity, consumer stalls, clears
      for (int s = 0; s < 150; s++) begin
         key_n_raw = 4'($urandom);
         hold      = int'($urandom_range(1, 30));
         rdy_pct   = int'($urandom_range(0, 100));
         for (int t = 0; t < hold; t++) begin
            evt_ready      = (int'($urandom_range(0, 99)) < rdy_pct);
            overflow_clear = ($urandom_range(0, 15) == 0);
            ts_clear       = ($urandom_range(0, 63) == 0);
            tick();
         end
      end
      evt_ready      = 1'b1;
      overflow_clear = 1'b0;
      ts_clear       = 1'b0;
      key_n_raw      = 4'hF;
      ticks(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
